// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts SOF/LEN/payload/CHK frames from a UART byte
// strobe stream, buffers the payload and releases it only once validated.
module uart_frame_parser #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic       busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_PAY,
        GET_CHK,
        DRAIN
    } state_t;

    state_t state, stateNxt;

    logic [7:0]    buffer [MAX_LEN];
    logic [IW-1:0] lenReg, lenNxt;
    logic [IW-1:0] idx, idxNxt, idxInc;
    logic [IW-1:0] rdIdx, rdNxt, rdInc;
    logic [7:0]    chkSum, chkNxt;
    logic [TW-1:0] toCnt, toNxt;
    logic [7:0]    dataNxt;
    logic          validNxt, lastNxt;
    logic          okNxt, errNxt, dropNxt;
    logic [1:0]    codeNxt;
    logic          wrEn;
    logic          collecting;

    assign idxInc     = idx + IW'(1);
    assign rdInc      = rdIdx + IW'(1);
    assign collecting = (state == GET_LEN) || (state == GET_PAY) ||
                        (state == GET_CHK);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        stateNxt = state;
        lenNxt   = lenReg;
        idxNxt   = idx;
        rdNxt    = rdIdx;
        chkNxt   = chkSum;
        toNxt    = toCnt;
        dataNxt  = out_data;
        validNxt = out_valid;
        lastNxt  = out_last;
        codeNxt  = err_code;
        okNxt    = 1'b0;
        errNxt   = 1'b0;
        dropNxt  = 1'b0;
        wrEn     = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_valid && rx_data == SOF) begin
                    stateNxt = GET_LEN;
                    toNxt    = '0;
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    toNxt = '0;
                    if (rx_data == 8'h00 || rx_data > LEN_MAX) begin
                        stateNxt = IDLE;
                        errNxt   = 1'b1;
                        codeNxt  = 2'b01;
                    end else begin
                        stateNxt = GET_PAY;
                        lenNxt   = rx_data[IW-1:0];
                        chkNxt   = rx_data;
                        idxNxt   = '0;
                    end
                end
            end
            GET_PAY: begin
                if (rx_valid) begin
                    toNxt  = '0;
                    wrEn   = 1'b1;
                    chkNxt = chkSum ^ rx_data;
                    idxNxt = idxInc;
                    if (idxInc == lenReg) begin
                        stateNxt = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    toNxt = '0;
                    if (rx_data == chkSum) begin
                        stateNxt = DRAIN;
                        okNxt    = 1'b1;
                        validNxt = 1'b1;
                        dataNxt  = buffer[0];
                        lastNxt  = (lenReg == IW'(1));
                        rdNxt    = '0;
                    end else begin
                        stateNxt = IDLE;
                        errNxt   = 1'b1;
                        codeNxt  = 2'b10;
                    end
                end
            end
            DRAIN: begin
                dropNxt = rx_valid;
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        stateNxt = IDLE;
                        validNxt = 1'b0;
                        lastNxt  = 1'b0;
                    end else begin
                        rdNxt   = rdInc;
                        dataNxt = buffer[rdInc[AW-1:0]];
                        lastNxt = (rdInc == lenReg - IW'(1));
                    end
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        // A strobe in the expiry cycle wins, so only silent cycles count.
        if (collecting && !rx_valid) begin
            if (toCnt == TO_LAST) begin
                stateNxt = IDLE;
                errNxt   = 1'b1;
                codeNxt  = 2'b11;
                toNxt    = '0;
            end else begin
                toNxt = toCnt + TW'(1);
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lenReg    <= '0;
            idx       <= '0;
            rdIdx     <= '0;
            chkSum    <= '0;
            toCnt     <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            rx_drop   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNxt;
            lenReg    <= lenNxt;
            idx       <= idxNxt;
            rdIdx     <= rdNxt;
            chkSum    <= chkNxt;
            toCnt     <= toNxt;
            out_data  <= dataNxt;
            out_valid <= validNxt;
            out_last  <= lastNxt;
            frame_ok  <= okNxt;
            frame_err <= errNxt;
            err_code  <= codeNxt;
            rx_drop   <= dropNxt;
            busy      <= (stateNxt != IDLE);
        end
    end

    // Payload storage; contents are irrelevant until written by a frame.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            buffer[idx[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frames with a scoreboard of expected
// payload bytes and frame events, checked by an independent monitor.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       rx_drop;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int dropsSeen = 0;
    int dropsExp = 0;

    // {last, data} of each byte expected on the output stream
    logic [8:0] expData[$];
    // 3'b100 = frame_ok, {1'b0, code} = frame_err with that code
    logic [2:0] expEvt[$];

    uart_frame_parser #(
        .MAX_LEN(16),
        .SOF    (8'hA5),
        .TIMEOUT(50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .rx_drop  (rx_drop),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDone(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy && expData.size() == 0 && expEvt.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_out_data"}, 32'(out_data), 32'h00);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_err_code"}, 32'(err_code), 32'd0);
        check({name, "_rx_drop"}, 32'(rx_drop), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: consumes the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin : mon
        logic [8:0] e;
        logic [2:0] ev;
        if (reset) begin
            if (out_valid && out_ready) begin
                if (expData.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             out_data);
                end else begin
                    e = expData.pop_front();
                    check("out_byte", 32'({out_last, out_data}), 32'(e));
                end
            end
            if (frame_ok || frame_err) begin
                ev = frame_ok ? 3'b100 : {1'b0, err_code};
                if (expEvt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none",
                             ev);
                end else begin
                    check("frame_event", 32'(ev), 32'(expEvt.pop_front()));
                end
            end
            if (rx_drop) dropsSeen++;
        end
    end

    initial begin
        logic [7:0] sum;
        reset     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        idle(2);
        checkResetOutputs("reset");
        reset = 1'b1;
        idle(2);

        // Good frame, sink always ready
        expEvt.push_back(3'b100);
        expData.push_back({1'b0, 8'h11});
        expData.push_back({1'b0, 8'h22});
        expData.push_back({1'b1, 8'h33});
        sendByte(8'hA5);
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h03);
        check("good_ok", 32'(frame_ok), 32'd1);
        check("good_valid", 32'(out_valid), 32'd1);
        check("good_first", 32'(out_data), 32'h11);
        idle(3);
        check("good_busy_drop", 32'(busy), 32'd0);
        check("good_valid_drop", 32'(out_valid), 32'd0);
        waitDone("good");

        // Bad checksum, then a good frame
        expEvt.push_back(3'b010);
        sendByte(8'hA5);
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h04);
        check("badchk_err", 32'(frame_err), 32'd1);
        check("badchk_code", 32'(err_code), 32'd2);
        check("badchk_valid", 32'(out_valid), 32'd0);
        idle(2);
        check("badchk_valid2", 32'(out_valid), 32'd0);
        expEvt.push_back(3'b100);
        expData.push_back({1'b0, 8'h44});
        expData.push_back({1'b1, 8'h55});
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h44);
        sendByte(8'h55);
        sendByte(8'h13);
        waitDone("after_badchk");

        // Bad lengths
        expEvt.push_back(3'b001);
        sendByte(8'hA5);
        sendByte(8'h00);
        check("len0_code", 32'(err_code), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        expEvt.push_back(3'b001);
        sendByte(8'hA5);
        sendByte(8'h11);
        check("len17_err", 32'(frame_err), 32'd1);
        check("len17_code", 32'(err_code), 32'd1);
        waitDone("badlen");

        // Maximum length frame
        expEvt.push_back(3'b100);
        sendByte(8'hA5);
        sendByte(8'h10);
        sum = 8'h10;
        for (int i = 0; i < 16; i++) begin
            expData.push_back({(i == 15), 8'(8'h10 + i)});
            sum = sum ^ 8'(8'h10 + i);
            sendByte(8'(8'h10 + i));
        end
        sendByte(sum);
        check("len16_ok", 32'(frame_ok), 32'd1);
        waitDone("len16");

        // Timeout after 50 silent cycles
        expEvt.push_back(3'b011);
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h11);
        idle(49);
        check("to_not_yet", 32'(frame_err), 32'd0);
        check("to_busy_49", 32'(busy), 32'd1);
        idle(1);
        check("to_err", 32'(frame_err), 32'd1);
        check("to_code", 32'(err_code), 32'd3);
        check("to_idle", 32'(busy), 32'd0);
        waitDone("timeout");

        // Byte on cycle 49 restarts the count; CHK lands on the expiry cycle
        expEvt.push_back(3'b100);
        expData.push_back({1'b0, 8'h11});
        expData.push_back({1'b1, 8'h22});
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h11);
        idle(48);
        sendByte(8'h22);
        idle(49);
        check("to_rearm_busy", 32'(busy), 32'd1);
        sendByte(8'h31);
        check("to_edge_ok", 32'(frame_ok), 32'd1);
        waitDone("to_rearm");

        // Backpressure and drop during DRAIN
        out_ready = 1'b0;
        expEvt.push_back(3'b100);
        expData.push_back({1'b0, 8'h11});
        expData.push_back({1'b0, 8'h22});
        expData.push_back({1'b1, 8'h33});
        sendByte(8'hA5);
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h03);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'(out_data), 32'h11);
            check("bp_hold_last", 32'(out_last), 32'd0);
            idle(1);
        end
        dropsExp++;
        sendByte(8'hA5);
        check("drop_pulse", 32'(rx_drop), 32'd1);
        check("drop_hold", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        waitDone("backpressure");

        // Reset in the middle of a frame
        sendByte(8'hA5);
        sendByte(8'h03);
        sendByte(8'h11);
        reset = 1'b0;
        #2;
        checkResetOutputs("midreset");
        idle(1);
        reset = 1'b1;
        expEvt.push_back(3'b100);
        expData.push_back({1'b1, 8'h7E});
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h7E);
        sendByte(8'h7F);
        check("post_reset_ok", 32'(frame_ok), 32'd1);
        waitDone("post_reset");

        idle(2);
        check("drop_count", 32'(dropsSeen), 32'(dropsExp));
        check("data_left", 32'(expData.size()), 32'd0);
        check("events_left", 32'(expEvt.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
